mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle RV32I control unit: FSM sequencing one instruction over 3-5 cycles on a shared memory/ALU datapath.
//  Successor to the single-cycle controller; adds an optional memory-ready handshake, full branch set, LUI/AUIPC.
//  Sits beside the multicycle datapath; drives its enables and muxes; ALUControl comes from the existing aludec.
// PARAMETERS
//  MEM_WAIT_EN  1  1: FETCH/MEMREAD/MEMWRITE hold until mem_ready; 0: mem_ready ignored, 1 cycle each
//  BRANCH_FULL  1  1: BEQ/BNE/BLT/BGE/BLTU/BGEU; 0: BEQ only (take = Zero, funct3 ignored)
// PORTS
//  clk          in   1  clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  op           in   7  instruction[6:0] from instruction register
//  funct3       in   3  instruction[14:12]
//  funct7b5     in   1  instruction[30]
//  Zero         in   1  ALU result == 0
//  Lt / Ltu     in   1  signed / unsigned rs1<rs2 from ALU compare
//  mem_ready    in   1  memory access completes this cycle
//  PCWrite      out  1  PC register enable
//  AdrSrc       out  1  0: PC, 1: ALUOut to memory address
//  MemWrite     out  1  data memory write strobe
//  IRWrite      out  1  instruction + OldPC register enable
//  RegWrite     out  1  register file write enable
//  ResultSrc    out  2  00 ALUOut, 01 ReadData, 10 ALUResult
//  ALUSrcA      out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
//  ALUSrcB      out  2  00 rs2, 01 ImmExt, 10 const 4
//  ImmSrc       out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational from op)
//  ALUControl   out  4  from aludec(op[5], funct3, funct7b5, ALUOp)
//  illegal      out  1  1-cycle pulse: unknown opcode decoded
// BEHAVIOUR
//  - rst_n low: state=FETCH immediately; PCWrite/IRWrite/RegWrite/MemWrite/illegal forced 0 while low.
//  - Moore outputs from state; PCWrite = PCUpdate | (Branch & take); undriven muxes default 0.
//  - FETCH: AdrSrc0 IRWrite A00 B10 ALUOp00 Res10 PCUpdate; ->DECODE (if MEM_WAIT_EN & !mem_ready: stay, all enables 0).
//  - DECODE: A01 B01 ALUOp00 (branch target). Next by op:
//    0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH,
//    1101111->JAL, 0110111->LUI, 0010111->AUIPC, other->FETCH with illegal=1.
//  - MEMADR: A10 B01 ALUOp00; ->MEMREAD if op[5]=0 else MEMWRITE.
//  - MEMREAD: AdrSrc1 Res00; ->MEMWB (waits on mem_ready as FETCH). MEMWB: Res01 RegWrite; ->FETCH.
//  - MEMWRITE: AdrSrc1 Res00 MemWrite; MemWrite held high while waiting; ->FETCH on ready.
//  - EXECR: A10 B00 ALUOp10. EXECI: A10 B01 ALUOp10. LUI: A11 B01 ALUOp00. AUIPC: A01 B01 ALUOp00. All ->ALUWB.
//  - ALUWB: Res00 RegWrite; ->FETCH.
//  - BRANCH: A10 B00 ALUOp01 Res00 Branch; take per funct3: 000 Zero, 001 !Zero, 100 Lt, 101 !Lt,
//    110 Ltu, 111 !Ltu, 010/011 -> take=0 + illegal pulse; ->FETCH.
//  - JAL: A01 B10 ALUOp00 Res00 PCUpdate (PC<=target, ALUResult=OldPC+4); ->ALUWB.
//  - Latency (MEM_WAIT_EN=0): branch 3, R/I/LUI/AUIPC/JAL/store 4, load 5 cycles.
//  - Reset mid-instruction: partial work abandoned; first cycle after release is a clean FETCH.
//  - Unreachable state encodings -> FETCH.
// STRUCTURE
//  - Package mc_ctrl_pkg: state_t enum, opcode localparams, ResultSrc/ALUSrcA/ALUSrcB encoding localparams.
//  - Instantiate the existing aludec unchanged; ALUOp is internal. FSM + branch logic in this module.
// TESTING
//  1 Reset: rst_n=0 mid-MEMREAD -> state FETCH, all enables 0; release -> IRWrite=1, PCWrite=1 first cycle.
//  2 add x3,x1,x2 (op 0110011): FETCH,DECODE,EXECR,ALUWB; ALUControl=0000, RegWrite only in cycle 4.
//  3 lw, MEM_WAIT_EN=1, mem_ready low 2 cycles in MEMREAD -> MEMREAD held 3 cycles, MEMWB once, Res=01.
//  4 bne, Zero=0 -> PCWrite=1 in BRANCH; Zero=1 -> PCWrite=0; BRANCH_FULL=0 same op -> behaves as beq.
//  5 bltu with Ltu=1 -> taken; funct3=010 in BRANCH -> PCWrite=0, illegal=1 one cycle.
//  6 op 1111111 -> DECODE->FETCH, illegal pulse 1 cycle, no RegWrite/MemWrite asserted.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared types and encodings for the multicycle RV32I controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_AUIPC    = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_controller_if.sv
// ============================================================================
//  Module      : mc_controller_if
//  Description : Controller <-> datapath signal bundle; master is the controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mc_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       Lt;
  logic       Ltu;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, Zero, Lt, Ltu, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero, Lt, Ltu, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );
endinterface

`default_nettype wire

// File: rtl/mc_controller_aludec.sv
// ============================================================================
//  Module      : aludec
//  Description : ALU operation decoder from ALUOp and instruction function bits.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module aludec
  import mc_ctrl_pkg::*;
(
  input  logic       opb5_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic [1:0] aluop_i,
  output logic [3:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = 4'b0000;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = 4'b0000;
      ALUOP_BR:  alucontrol_o = 4'b0001;
      default: begin
        case (funct3_i)
          3'b000:  alucontrol_o = (opb5_i & funct7b5_i) ? 4'b0001 : 4'b0000;
          3'b001:  alucontrol_o = 4'b0010;
          3'b010:  alucontrol_o = 4'b0011;
          3'b011:  alucontrol_o = 4'b0100;
          3'b100:  alucontrol_o = 4'b0101;
          3'b101:  alucontrol_o = funct7b5_i ? 4'b0111 : 4'b0110;
          3'b110:  alucontrol_o = 4'b1000;
          default: alucontrol_o = 4'b1001;
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ============================================================================
//  Module      : mc_controller
//  Description : Multicycle RV32I control FSM with memory-ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit BRANCH_FULL = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  mc_controller_if.master bus
);

  state_t     state_q, state_d;
  logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, ill;
  logic [1:0] res_src, src_a, src_b, alu_op;
  logic       take, bad_f3, mem_wait;

  assign mem_wait = MEM_WAIT_EN && !bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    take   = 1'b0;
    bad_f3 = 1'b0;
    if (BRANCH_FULL) begin
      case (bus.funct3)
        3'b000:  take = bus.Zero;
        3'b001:  take = !bus.Zero;
        3'b100:  take = bus.Lt;
        3'b101:  take = !bus.Lt;
        3'b110:  take = bus.Ltu;
        3'b111:  take = !bus.Ltu;
        default: bad_f3 = 1'b1;
      endcase
    end else begin
      take = bus.Zero;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_update = 1'b0;
    branch    = 1'b0;
    adr_src   = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    ill       = 1'b0;
    res_src   = RES_ALUOUT;
    src_a     = SRCA_PC;
    src_b     = SRCB_RS2;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        src_a   = SRCA_PC;
        src_b   = SRCB_FOUR;
        res_src = RES_ALURES;
        if (!mem_wait) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut.
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            ill     = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (!mem_wait) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_src   = RES_RDATA;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (!mem_wait) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_RS2;
        alu_op  = ALUOP_FUNC;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        alu_op  = ALUOP_FUNC;
        state_d = S_ALUWB;
      end
      S_LUI: begin
        src_a   = SRCA_ZERO;
        src_b   = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_IMM;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_RS2;
        alu_op  = ALUOP_BR;
        branch  = 1'b1;
        ill     = bad_f3;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC takes the DECODE target while ALUResult forms the link value.
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.PCWrite   = rst_n & (pc_update | (branch & take));
  assign bus.IRWrite   = rst_n & ir_write;
  assign bus.RegWrite  = rst_n & reg_write;
  assign bus.MemWrite  = rst_n & mem_write;
  assign bus.illegal   = rst_n & ill;
  assign bus.AdrSrc    = adr_src;
  assign bus.ResultSrc = res_src;
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;
  assign bus.ImmSrc    = imm_src(bus.op);

  aludec u_aludec (
    .opb5_i       (bus.op[5]),
    .funct3_i     (bus.funct3),
    .funct7b5_i   (bus.funct7b5),
    .aluop_i      (alu_op),
    .alucontrol_o (bus.ALUControl)
  );

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
//  Module      : tb_mc_controller
//  Description : Randomized bench comparing per-cycle controls to an instruction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_t;
  logic [2:0] f3_t;
  logic       f7_t, zero_t, lt_t, ltu_t, rdy_t;

  mc_controller_if ifa ();
  mc_controller_if ifb ();

  assign ifa.op = op_t;   assign ifa.funct3 = f3_t; assign ifa.funct7b5 = f7_t;
  assign ifa.Zero = zero_t; assign ifa.Lt = lt_t; assign ifa.Ltu = ltu_t;
  assign ifa.mem_ready = rdy_t;
  assign ifb.op = op_t;   assign ifb.funct3 = f3_t; assign ifb.funct7b5 = f7_t;
  assign ifb.Zero = zero_t; assign ifb.Lt = lt_t; assign ifb.Ltu = ltu_t;
  assign ifb.mem_ready = rdy_t;

  mc_controller #(.MEM_WAIT_EN(1'b1), .BRANCH_FULL(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mc_controller #(.MEM_WAIT_EN(1'b0), .BRANCH_FULL(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  logic [18:0] obs_a, obs_b;
  assign obs_a = {ifa.PCWrite, ifa.AdrSrc, ifa.MemWrite, ifa.IRWrite, ifa.RegWrite, ifa.ResultSrc,
                  ifa.ALUSrcA, ifa.ALUSrcB, ifa.ImmSrc, ifa.ALUControl, ifa.illegal};
  assign obs_b = {ifb.PCWrite, ifb.AdrSrc, ifb.MemWrite, ifb.IRWrite, ifb.RegWrite, ifb.ResultSrc,
                  ifb.ALUSrcA, ifb.ALUSrcB, ifb.ImmSrc, ifb.ALUControl, ifb.illegal};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %05h expected %05h", tag, $time, got, exp);
    end
  endtask

  // Current instruction fields used by the model
  logic [6:0] i_op;
  logic [2:0] i_f3;
  logic       i_f7, i_zero, i_lt, i_ltu;
  bit         sel_b;

  logic [18:0] exp_q[$];
  bit          rdy_q[$];

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    if (o == OP_STORE)                  return 3'b001;
    if (o == OP_BRANCH)                 return 3'b010;
    if (o == OP_JAL)                    return 3'b011;
    if (o == OP_LUI || o == OP_AUIPC)   return 3'b100;
    return 3'b000;
  endfunction

  // add=0, sub=1, sll=2, slt=3, sltu=4, xor=5, srl=6, sra=7, or=8, and=9
  function automatic logic [3:0] exp_alu(input logic [1:0] aop);
    if (aop == 2'b00) return 4'd0;
    if (aop == 2'b01) return 4'd1;
    case (i_f3)
      3'd0: return (i_op[5] && i_f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd2;
      3'd2: return 4'd3;
      3'd3: return 4'd4;
      3'd4: return 4'd5;
      3'd5: return i_f7 ? 4'd7 : 4'd6;
      3'd6: return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  function automatic logic [18:0] vec(input bit pcw, input bit adr, input bit mw, input bit irw,
                                      input bit rw, input logic [1:0] res, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] aop, input bit ill);
    return {pcw, adr, mw, irw, rw, res, a, b, exp_imm(i_op), exp_alu(aop), ill};
  endfunction

  task automatic push_plain(input logic [18:0] v);
    exp_q.push_back(v);
    rdy_q.push_back(1'($urandom));
  endtask

  task automatic push_wait(input logic [18:0] stall, input logic [18:0] step, input int waits,
                           input bit wait_en);
    if (wait_en) begin
      for (int i = 0; i < waits; i++) begin
        exp_q.push_back(stall);
        rdy_q.push_back(1'b0);
      end
      exp_q.push_back(step);
      rdy_q.push_back(1'b1);
    end else begin
      push_plain(step);
    end
  endtask

  task automatic build(input int fw, input int mw, input bit wait_en, input bit full);
    bit known, take, ill;
    logic [18:0] aluwb, mem;
    exp_q.delete();
    rdy_q.delete();
    known = (i_op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC});
    aluwb = vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    push_wait(vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0),
              vec(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0), fw, wait_en);
    push_plain(vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, !known));
    if (i_op == OP_LOAD || i_op == OP_STORE) begin
      push_plain(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0));
      mem = vec(0, 1, i_op == OP_STORE, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      push_wait(mem, mem, mw, wait_en);
      if (i_op == OP_LOAD) push_plain(vec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0));
    end else if (i_op == OP_RTYPE) begin
      push_plain(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0)); push_plain(aluwb);
    end else if (i_op == OP_ITYPE) begin
      push_plain(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0)); push_plain(aluwb);
    end else if (i_op == OP_LUI) begin
      push_plain(vec(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00, 0)); push_plain(aluwb);
    end else if (i_op == OP_AUIPC) begin
      push_plain(vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0)); push_plain(aluwb);
    end else if (i_op == OP_JAL) begin
      push_plain(vec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0)); push_plain(aluwb);
    end else if (i_op == OP_BRANCH) begin
      ill = 0;
      if (!full) take = i_zero;
      else begin
        case (i_f3)
          3'd0: take = i_zero;
          3'd1: take = !i_zero;
          3'd4: take = i_lt;
          3'd5: take = !i_lt;
          3'd6: take = i_ltu;
          3'd7: take = !i_ltu;
          default: begin take = 0; ill = 1; end
        endcase
      end
      push_plain(vec(take, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, ill));
    end
  endtask

  task automatic run(input string tag, input int limit);
    for (int c = 0; c < exp_q.size() && c < limit; c++) begin
      @(negedge clk);
      op_t = i_op; f3_t = i_f3; f7_t = i_f7;
      zero_t = i_zero; lt_t = i_lt; ltu_t = i_ltu;
      rdy_t = rdy_q[c];
      #1;
      check_eq(tag, sel_b ? obs_b : obs_a, exp_q[c]);
    end
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                           input bit z, input bit lt, input bit ltu);
    i_op = o; i_f3 = f3; i_f7 = f7; i_zero = z; i_lt = lt; i_ltu = ltu;
  endtask

  task automatic rand_instr();
    logic [6:0] o;
    case ($urandom_range(0, 9))
      0: o = OP_LOAD;   1: o = OP_STORE; 2: o = OP_RTYPE; 3: o = OP_ITYPE;
      4: o = OP_BRANCH; 5: o = OP_JAL;   6: o = OP_LUI;   7: o = OP_AUIPC;
      8: o = 7'b1111111;
      default: o = 7'($urandom);
    endcase
    set_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Enables must be low during reset; release lands just after a rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    op_t = i_op; f3_t = i_f3; f7_t = i_f7; rdy_t = 1'b1;
    #1;
    check_eq("reset_a", obs_a, vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0));
    check_eq("reset_b", obs_b, vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0));
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    sel_b = 1'b0;
    rdy_t = 1'b1;
    set_instr(OP_RTYPE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    set_instr(OP_RTYPE, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);  build(0, 0, 1, 1); run("add", 99);
    set_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);   build(0, 2, 1, 1); run("lw_wait", 99);
    set_instr(OP_BRANCH, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0); build(0, 0, 1, 1); run("bne_taken", 99);
    set_instr(OP_BRANCH, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0); build(0, 0, 1, 1); run("bne_not", 99);
    set_instr(OP_BRANCH, 3'd6, 1'b0, 1'b0, 1'b0, 1'b1); build(0, 0, 1, 1); run("bltu", 99);
    set_instr(OP_BRANCH, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1); build(0, 0, 1, 1); run("br_f3_bad", 99);
    set_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); build(1, 0, 1, 1); run("bad_op", 99);
    set_instr(OP_STORE, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);  build(2, 2, 1, 1); run("sw_wait", 99);

    // Abandon a load while it is stalled in the read phase
    set_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);   build(1, 2, 1, 1); run("lw_abort", 5);
    do_reset();

    for (int i = 0; i < 60; i++) begin
      rand_instr();
      build($urandom_range(0, 2), $urandom_range(0, 2), 1, 1);
      run("rand_a", 99);
    end

    sel_b = 1'b1;
    do_reset();
    set_instr(OP_BRANCH, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0); build(0, 0, 0, 0); run("b_bne_as_beq0", 99);
    set_instr(OP_BRANCH, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0); build(0, 0, 0, 0); run("b_bne_as_beq1", 99);
    set_instr(OP_BRANCH, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0); build(0, 0, 0, 0); run("b_f3_ignored", 99);
    set_instr(OP_LOAD, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);   build(0, 0, 0, 0); run("b_lw_5cyc", 99);
    for (int i = 0; i < 40; i++) begin
      rand_instr();
      build(0, 0, 0, 0);
      run("rand_b", 99);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
